// File: rtl/serial_addsub.sv
// Digit-serial signed adder/subtractor processing DIGIT bits per clock, LSB first.
// Defining SERIAL_ADDSUB_ABORT_EN adds an abort input that cancels a run in progress.
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
`ifdef SERIAL_ADDSUB_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow,
  output logic             carry_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_width_check
    $error("serial_addsub: WIDTH must be at least 2");
  end

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_check
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] bx_reg;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             carry;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;
  logic             msb_a;
  logic             msb_bx;
  logic             msb_s;
  logic             last;
  logic             abort_req;

`ifdef SERIAL_ADDSUB_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Operands shift right each digit, so the current digit always sits in the low bits;
  // on the final digit those low bits hold the operand MSBs needed for sign/overflow.
  always_comb begin
    digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, bx_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    res_next  = (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    msb_a     = a_reg[DIGIT-1];
    msb_bx    = bx_reg[DIGIT-1];
    msb_s     = digit_sum[DIGIT-1];
    last      = (count == CW'(N - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      count     <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      bx_reg    <= '0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a;
            bx_reg <= sub ? ~b : b;
            carry  <= sub;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort_req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_reg  <= a_reg >> DIGIT;
            bx_reg <= bx_reg >> DIGIT;
            res    <= res_next;
            carry  <= digit_sum[DIGIT];
            count  <= count + 1'b1;
            // Carry into the MSB is recovered as a^bx^s of that bit.
            if (last) begin
              sum       <= {msb_a ^ msb_bx ^ digit_sum[DIGIT], res_next};
              overflow  <= msb_a ^ msb_bx ^ msb_s ^ digit_sum[DIGIT];
              carry_out <= digit_sum[DIGIT];
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: three instances (DIGIT 1, 4, 8) driven by shared directed vectors.
// The abort sequence is compiled in only when SERIAL_ADDSUB_ABORT_EN is defined.
module tb_serial_addsub;

  localparam int WIDTH = 32;
  localparam int LAT [3] = '{32, 8, 4};

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic             cout;
  } vec_t;

  logic             clock;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy      [3];
  logic             done      [3];
  logic [WIDTH:0]   sum       [3];
  logic             overflow  [3];
  logic             carry_out [3];
`ifdef SERIAL_ADDSUB_ABORT_EN
  logic             abort;
`endif

  int             checks;
  int             errors;
  logic [WIDTH:0] last_sum;
  vec_t           vecs [9];

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(1)) u_d1 (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(abort),
`endif
    .a(a), .b(b), .busy(busy[0]), .done(done[0]), .sum(sum[0]),
    .overflow(overflow[0]), .carry_out(carry_out[0])
  );

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(4)) u_d4 (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(abort),
`endif
    .a(a), .b(b), .busy(busy[1]), .done(done[1]), .sum(sum[1]),
    .overflow(overflow[1]), .carry_out(carry_out[1])
  );

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(8)) u_d8 (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
`ifdef SERIAL_ADDSUB_ABORT_EN
    .abort(abort),
`endif
    .a(a), .b(b), .busy(busy[2]), .done(done[2]), .sum(sum[2]),
    .overflow(overflow[2]), .carry_out(carry_out[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Entered #1 after a rising edge with every instance idle; operands are scrambled after acceptance.
  task automatic apply_stimulus(input vec_t v, input int idx);
    int done_at  [3];
    int done_cnt [3];
    bit held     [3];
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; a = ~v.a; b = v.b ^ 32'h5A5A_5A5A; sub = ~v.sub;
    check_output($sformatf("v%0d busy", idx), 64'(busy[0]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      done_at[i] = -1; done_cnt[i] = 0; held[i] = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = c;
        end else if (done_at[i] < 0 && sum[i] !== last_sum) begin
          held[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("v%0d u%0d latency", idx, i), 64'(done_at[i]), 64'(LAT[i]));
      check_output($sformatf("v%0d u%0d done_pulses", idx, i), 64'(done_cnt[i]), 64'd1);
      check_output($sformatf("v%0d u%0d sum_held", idx, i), 64'(held[i]), 64'd1);
      check_output($sformatf("v%0d u%0d sum", idx, i), 64'(sum[i]), 64'(v.sum));
      check_output($sformatf("v%0d u%0d overflow", idx, i), 64'(overflow[i]), 64'(v.ovf));
      check_output($sformatf("v%0d u%0d carry_out", idx, i), 64'(carry_out[i]), 64'(v.cout));
    end
    last_sum = v.sum;
  endtask

  initial begin
    int first, second, dcount;
    logic [WIDTH:0] s1, s2;

    vecs[0] = '{a:32'd5,         b:32'd7,         sub:1'b0, sum:33'h0_0000_000C, ovf:1'b0, cout:1'b0};
    vecs[1] = '{a:32'h7FFF_FFFF, b:32'd1,         sub:1'b0, sum:33'h0_8000_0000, ovf:1'b1, cout:1'b0};
    vecs[2] = '{a:32'h8000_0000, b:32'd1,         sub:1'b1, sum:33'h1_7FFF_FFFF, ovf:1'b1, cout:1'b1};
    vecs[3] = '{a:32'd5,         b:32'd7,         sub:1'b1, sum:33'h1_FFFF_FFFE, ovf:1'b0, cout:1'b0};
    vecs[4] = '{a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, sub:1'b0, sum:33'h1_FFFF_FFFE, ovf:1'b0, cout:1'b1};
    vecs[5] = '{a:32'h8000_0000, b:32'h8000_0000, sub:1'b0, sum:33'h1_0000_0000, ovf:1'b1, cout:1'b1};
    vecs[6] = '{a:32'd0,         b:32'd0,         sub:1'b1, sum:33'h0_0000_0000, ovf:1'b0, cout:1'b1};
    vecs[7] = '{a:32'h1234_5678, b:32'h0FED_CBA8, sub:1'b0, sum:33'h0_2222_2220, ovf:1'b0, cout:1'b0};
    vecs[8] = '{a:32'h7FFF_FFFF, b:32'hFFFF_FFFF, sub:1'b1, sum:33'h0_8000_0000, ovf:1'b1, cout:1'b0};

    checks = 0; errors = 0; last_sum = '0;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADDSUB_ABORT_EN
    abort = 1'b0;
`endif

    #12;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("reset u%0d sum", i), 64'(sum[i]), 64'd0);
      check_output($sformatf("reset u%0d busy_done", i), 64'({busy[i], done[i]}), 64'd0);
      check_output($sformatf("reset u%0d flags", i), 64'({overflow[i], carry_out[i]}), 64'd0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 9; v++) apply_stimulus(vecs[v], v);

    // start held high: second operation is accepted on the first IDLE edge, 34 cycles later
    a = 32'd100; b = 32'd23; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    a = 32'd50; b = 32'd8; sub = 1'b1;
    first = -1; second = -1; s1 = '0; s2 = '0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clock); #1;
      if (c == 34) start = 1'b0;
      if (done[0]) begin
        if (first < 0) begin
          first = c; s1 = sum[0];
        end else if (second < 0) begin
          second = c; s2 = sum[0];
        end
      end
    end
    check_output("held first_done", 64'(first), 64'd32);
    check_output("held second_done", 64'(second), 64'd66);
    check_output("held first_sum", 64'(s1), 64'd123);
    check_output("held second_sum", 64'(s2), 64'd42);
    repeat (20) @(posedge clock);
    #1;

    // reset asserted mid-cycle after ten digits
    a = 32'd5; b = 32'd7; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_output("midrun_reset sum", 64'(sum[0]), 64'd0);
    check_output("midrun_reset busy", 64'(busy[0]), 64'd0);
    check_output("midrun_reset flags", 64'({overflow[0], carry_out[0], done[0]}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) if (done[i]) dcount++;
    end
    check_output("midrun_reset no_done", 64'(dcount), 64'd0);
    last_sum = '0;
    apply_stimulus(vecs[0], 9);

`ifdef SERIAL_ADDSUB_ABORT_EN
    a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dcount = 0;
    repeat (5) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check_output("abort busy", 64'(busy[0]), 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done[0]) dcount++;
    end
    check_output("abort no_done", 64'(dcount), 64'd0);
    check_output("abort sum_kept", 64'(sum[0]), 64'(last_sum));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, minimum 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle; WIDTH mod DIGIT SHALL be 0, and a violation is a static elaboration error.
REQ-003 SHALL have port clock  input  1  clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  operation request; sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  signed operand A; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  signed operand B; sampled with start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH+1  signed full-precision result.
REQ-012 SHALL have port overflow  output  1  signed overflow of the WIDTH-bit truncated result.
REQ-013 SHALL have port carry_out  output  1  unsigned carry out of bit WIDTH-1 (borrow-inverted when sub=1).

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the last digit; DONE->IDLE unconditionally.
REQ-015 On the edge accepting start, SHALL latch a, sub and the effective operand bx (b, or ~b when sub=1), clear the digit counter, and set the internal carry to sub.
REQ-016 In RUN, each edge SHALL add DIGIT bits of a, bx and the carry, store DIGIT result bits LSB-first in an internal shift register, and propagate the carry to the next digit.
REQ-017 Latency SHALL be N = WIDTH/DIGIT: with start accepted at edge k, sum, overflow, carry_out and done SHALL update at edge k+N, and done SHALL be low again at edge k+N+1.
REQ-018 sum[WIDTH-1:0] SHALL equal (a ± b) mod 2^WIDTH, and sum[WIDTH] SHALL equal a[WIDTH-1] ^ bx[WIDTH-1] ^ carry_out, giving the exact signed result.
REQ-019 overflow SHALL equal the carry into the MSB digit bit WIDTH-1 XOR carry_out.
REQ-020 sum, overflow and carry_out SHALL hold their last values until the next completion; partial results SHALL never be visible on them.
REQ-021 start in RUN or DONE SHALL be ignored; start held high SHALL begin a new operation on the first edge in IDLE.
REQ-022 Operand and sub changes after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-023 reset SHALL force state IDLE, busy=0, done=0, sum=0, overflow=0, carry_out=0, counter=0 and internal carry=0, immediately and regardless of clock.
REQ-024 reset mid-RUN SHALL discard the operation; done SHALL NOT pulse for it.

Configuration
REQ-025 With macro SERIAL_ADDSUB_ABORT_EN defined, SHALL add port abort  input  1; abort high in RUN SHALL return to IDLE on the next edge with no done pulse and with sum, overflow and carry_out unchanged; abort SHALL be ignored outside RUN; abort and start together in IDLE SHALL start normally.
REQ-026 Without SERIAL_ADDSUB_ABORT_EN, the abort port SHALL be absent and RUN SHALL always complete.

Verification
REQ-027 WIDTH=32, DIGIT=1, a=5, b=7, sub=0 -> done exactly 32 cycles after the start edge; sum=12; overflow=0; carry_out=0.
REQ-028 WIDTH=32, DIGIT=8, a=0x7FFFFFFF, b=1, sub=0 -> done after 4 cycles; sum=0x080000000; overflow=1; carry_out=0.
REQ-029 WIDTH=32, DIGIT=4, a=0x80000000, b=1, sub=1 -> sum=0x17FFFFFFF (= -2^31-1); overflow=1; carry_out=1.
REQ-030 WIDTH=32, DIGIT=1: start held high, operands changed mid-RUN -> result matches the latched operands; back-to-back operations produce done every 34 cycles.
REQ-031 Assert reset at digit 10 of a run -> outputs zero immediately; no done; the next start completes correctly.
REQ-032 With SERIAL_ADDSUB_ABORT_EN defined: abort at digit 5 -> IDLE next cycle; previous sum retained; no done pulse.
